// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (counterpart of uart_tx).
// Accepts host command bytes from the USB-UART bridge. The line is
// synchronized, false starts are rejected, and a low stop bit is flagged.
//
// Ports:
//   clk            system clock
//   rst            asynchronous reset, active-high
//   rx             serial line, idle high, asynchronous to clk
//   rx_data        last correctly received word (held until the next good frame)
//   rx_data_valid  one-cycle strobe, rx_data is new this cycle
//   receiving      high while a frame is in progress (START, DATA, STOP)
//   framing_error  one-cycle strobe, stop bit sampled low
//
// CLKS_PER_BIT must be >= 4.
module uart_rx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_data_valid,
    output logic             receiving,
    output logic             framing_error
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state, state_n;
    logic               rx_m, rx_s;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [WIDTH-1:0]   shift, shift_n;
    logic [WIDTH-1:0]   rx_data_n;
    logic               valid_n;
    logic               ferr_n;
    logic               receiving_n;

    // Two-flop synchronizer; only rx_s is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b0;
            rx_s <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_WAIT_IDLE;
            cnt           <= '0;
            idx           <= '0;
            shift         <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            framing_error <= 1'b0;
            receiving     <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            shift         <= shift_n;
            rx_data       <= rx_data_n;
            rx_data_valid <= valid_n;
            framing_error <= ferr_n;
            receiving     <= receiving_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        shift_n   = shift;
        rx_data_n = rx_data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;

        case (state)
            // A line held low (break, or reset mid-frame) must go high
            // before a falling edge can count as a start bit.
            S_WAIT_IDLE: begin
                cnt_n = '0;
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = S_START;
                end
            end
            // Re-check at mid start bit; a high line here was a glitch.
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n          = '0;
                    shift_n[idx]   = rx_s;
                    idx_n          = idx + IDX_W'(1);
                    if (idx == IDX_LAST) begin
                        state_n = S_STOP;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            // Leaving at mid stop bit lets a back-to-back start edge be caught.
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        rx_data_n = shift;
                        valid_n   = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_WAIT_IDLE;
            end
        endcase

        receiving_n = (state_n == S_START) || (state_n == S_DATA) || (state_n == S_STOP);
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at CLKS_PER_BIT=16 (u_a) and 104 (u_b).
module tb_uart_rx;

    localparam int unsigned W     = 8;
    localparam int unsigned CPB_A = 16;
    localparam int unsigned CPB_B = 104;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_a = 1'b1;
    logic         rx_b = 1'b1;
    logic [W-1:0] data_a, data_b;
    logic         val_a, val_b, rcv_a, rcv_b, fe_a, fe_b;

    uart_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB_A)) u_a (
        .clk(clk), .rst(rst), .rx(rx_a),
        .rx_data(data_a), .rx_data_valid(val_a),
        .receiving(rcv_a), .framing_error(fe_a)
    );

    uart_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB_B)) u_b (
        .clk(clk), .rst(rst), .rx(rx_b),
        .rx_data(data_b), .rx_data_valid(val_b),
        .receiving(rcv_b), .framing_error(fe_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] d;
        int           t0;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int fe_cnt_a   = 0;
    int fe_cnt_b   = 0;
    int rcv_cyc_a  = 0;
    int last_val_a = -1;
    int gap_a      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Start-bit drive to strobe-visible negedge: the first sync flop captures
    // one edge after the drive, then 2 sync cycles + 9.5 bits to the stop sample.
    function automatic logic lat_ok(input int d, input int cpb);
        int e;
        e = 3 + ((2 * W + 3) * cpb) / 2;
        return (d >= e - 1) && (d <= e + 1);
    endfunction

    // Scoreboard / monitor for u_a.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rcv_a) rcv_cyc_a++;
            if (fe_a) fe_cnt_a++;
            if (val_a && fe_a) check("val_and_fe_a", 1, 0);
            if (val_a) begin
                if (q_a.size() == 0) begin
                    check("spurious_val_a", 1, 0);
                end else begin
                    e = q_a.pop_front();
                    check("data_a", 32'(data_a), 32'(e.d));
                    check("lat_a", 32'(lat_ok(cyc - e.t0, CPB_A)), 1);
                end
                if (last_val_a >= 0) gap_a = cyc - last_val_a;
                last_val_a = cyc;
            end
        end
    end

    // Scoreboard / monitor for u_b.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (fe_b) fe_cnt_b++;
            if (val_b) begin
                if (q_b.size() == 0) begin
                    check("spurious_val_b", 1, 0);
                end else begin
                    e = q_b.pop_front();
                    check("data_b", 32'(data_b), 32'(e.d));
                    check("lat_b", 32'(lat_ok(cyc - e.t0, CPB_B)), 1);
                end
            end
        end
    end

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic hold(input bit sel, input logic v, input int n);
        set_rx(sel, v);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at the current negedge; good frames go to the scoreboard.
    task automatic send_frame(input bit sel, input logic [W-1:0] d, input logic stop);
        int   cpb;
        exp_t e;
        cpb = sel ? int'(CPB_B) : int'(CPB_A);
        if (stop) begin
            e.d  = d;
            e.t0 = cyc;
            if (sel) q_b.push_back(e);
            else     q_a.push_back(e);
        end
        hold(sel, 1'b0, cpb);
        for (int i = 0; i < int'(W); i++) hold(sel, d[i], cpb);
        hold(sel, stop, cpb);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data_a"}, 32'(data_a), 0);
        check({tag, "_val_a"},  32'(val_a), 0);
        check({tag, "_rcv_a"},  32'(rcv_a), 0);
        check({tag, "_fe_a"},   32'(fe_a), 0);
        check({tag, "_data_b"}, 32'(data_b), 0);
    endtask

    initial begin
        logic [W-1:0] c3;
        c3 = 8'hC3;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        hold(1, 1'b1, 1);
        hold(0, 1'b1, 20);

        // Single frame; receiving spans 8 + 8*16 + 16 cycles.
        rcv_cyc_a = 0;
        send_frame(0, 8'hA5, 1'b1);
        hold(0, 1'b1, 20);
        check("rcv_len_a5", 32'(rcv_cyc_a), 152);
        check("fe_none_a5", 32'(fe_cnt_a), 0);

        // Back-to-back frames, strobes one frame (10 bits) apart.
        last_val_a = -1;
        send_frame(0, 8'h55, 1'b1);
        send_frame(0, 8'h3C, 1'b1);
        hold(0, 1'b1, 20);
        check("b2b_gap", 32'(gap_a), 160);
        check("b2b_drained", 32'(q_a.size()), 0);

        // False start: 5-cycle low pulse is rejected at the mid-start sample.
        rcv_cyc_a = 0;
        hold(0, 1'b0, 5);
        hold(0, 1'b1, 30);
        check("glitch_rcv_seen", 32'(rcv_cyc_a > 0), 1);
        check("glitch_rcv_short", 32'(rcv_cyc_a <= 8), 1);
        check("glitch_no_fe", 32'(fe_cnt_a), 0);
        send_frame(0, 8'h81, 1'b1);
        hold(0, 1'b1, 20);

        // Framing error followed by a long break.
        fe_cnt_a = 0;
        send_frame(0, 8'h00, 1'b0);
        rcv_cyc_a = 0;
        hold(0, 1'b0, 30 * int'(CPB_A));
        check("break_fe_once", 32'(fe_cnt_a), 1);
        check("break_no_rcv", 32'(rcv_cyc_a), 0);
        check("break_data_kept", 32'(data_a), 32'h81);
        hold(0, 1'b1, 20);
        send_frame(0, 8'hF0, 1'b1);
        hold(0, 1'b1, 20);
        check("after_break_fe", 32'(fe_cnt_a), 1);

        // Reset during bit 3 of 0xC3 with the line low at release.
        hold(0, 1'b0, CPB_A);
        for (int i = 0; i < 3; i++) hold(0, c3[i], CPB_A);
        hold(0, c3[3], CPB_A / 2);
        rst = 1'b1;
        set_rx(0, 1'b0);
        repeat (2) @(negedge clk);
        check_outputs_zero("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rcv_cyc_a = 0;
        hold(0, 1'b0, 40);
        check("wait_idle_rcv", 32'(rcv_cyc_a), 0);
        check("wait_idle_data", 32'(data_a), 0);
        hold(0, 1'b1, 20);
        send_frame(0, 8'h7E, 1'b1);
        hold(0, 1'b1, 20);

        // Slow instance: sample timing checked through strobe latency.
        hold(1, 1'b1, 20);
        send_frame(1, 8'hFF, 1'b1);
        hold(1, 1'b1, 50);
        send_frame(1, 8'h01, 1'b1);
        hold(1, 1'b1, 200);

        check("final_q_a", 32'(q_a.size()), 0);
        check("final_q_b", 32'(q_b.size()), 0);
        check("final_fe_b", 32'(fe_cnt_b), 0);
        check("final_data_b", 32'(data_b), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
